// File: rtl/grid_loader.sv
// grid_loader: packs '@'/'.' grid rows into DATA_W-bit vectors and writes each vector to mem.
// A write issues the cycle after its vector completes unless mem is busy; char_ready stays low until mem is idle.
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 4
`endif
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 8
`endif

module grid_loader #(
   parameter int DATA_W = `TX_DATA_WIDTH,
   parameter int ROW_W  = `BANK_ADDR_WIDTH,
   parameter int COL_W  = `COL_ADDR_WIDTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              char_valid,
   input  logic [7:0]        char_in,
   output logic              char_ready,
   input  logic              end_in,
   output logic              write_en,
   output logic [ROW_W-1:0]  row_addr_in,
   output logic [COL_W-1:0]  col_addr_in,
   output logic [DATA_W-1:0] partial_vec_in,
   input  logic              busy,
   output logic              done,
   output logic [ROW_W-1:0]  num_rows,
   output logic [COL_W-1:0]  num_cols,
   output logic              err
);

   localparam int CW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {FILL, ISSUE, WAIT, DONE} state_t;
   state_t state, state_nxt;

   logic [DATA_W-1:0] acc, acc_nxt;
   logic [CW-1:0]     cell_cnt, cnt_nxt;
   // One extra bit so the column counter can flag cells past the last address.
   logic [COL_W:0]    col, col_nxt;
   logic [ROW_W-1:0]  row;
   logic              eol, fin, cols_set;

   logic accept, end_req, is_nl, is_cr, is_at, is_dot, is_cell, take, bad, drop;
   logic vec_full, row_req, row_empty, row_max;
   logic issue_go, complete;
   logic [COL_W-1:0] col_base;

   assign accept    = (state == FILL) && char_valid;
   assign end_req   = (state == FILL) && end_in;
   assign is_nl     = (char_in == 8'h0A);
   assign is_cr     = (char_in == 8'h0D);
   assign is_at     = (char_in == 8'h40);
   assign is_dot    = (char_in == 8'h2E);
   assign is_cell   = accept && !is_nl && !is_cr;
   assign take      = is_cell && !col[COL_W];
   assign drop      = is_cell && col[COL_W];
   assign bad       = is_cell && !is_at && !is_dot;
   assign col_nxt   = col + {{COL_W{1'b0}}, take};
   assign cnt_nxt   = cell_cnt + {{(CW-1){1'b0}}, take};
   assign vec_full  = (cnt_nxt == CW'(DATA_W));
   assign row_req   = (accept && is_nl) || end_req;
   assign row_empty = (col_nxt == '0);
   assign row_max   = &row;
   assign col_base  = col[COL_W-1:0] - COL_W'(cell_cnt);
   assign num_rows  = row;

   always_comb begin
      acc_nxt = acc;
      for (int i = 0; i < DATA_W; i++) begin
         if (take && (cell_cnt == CW'(i))) acc_nxt[i] = is_at;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= FILL;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      issue_go   = 1'b0;
      complete   = 1'b0;
      write_en   = 1'b0;
      char_ready = 1'b0;
      done       = 1'b0;
      case (state)
         FILL: begin
            char_ready = reset;
            if (vec_full) begin
               issue_go  = 1'b1;
               state_nxt = ISSUE;
            end else if (row_req) begin
               if (row_empty) begin
                  state_nxt = DONE;
               end else if (cnt_nxt != '0) begin
                  issue_go  = 1'b1;
                  state_nxt = ISSUE;
               end else begin
                  // Row length is a multiple of DATA_W: its last vector is already written.
                  complete = 1'b1;
                  if (end_req || row_max) state_nxt = DONE;
               end
            end
         end
         ISSUE: begin
            if (!busy) begin
               write_en  = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (!busy) begin
               complete  = eol;
               state_nxt = (fin || (eol && row_max)) ? DONE : FILL;
            end
         end
         DONE: done = 1'b1;
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc            <= '0;
         cell_cnt       <= '0;
         col            <= '0;
         row            <= '0;
         eol            <= 1'b0;
         fin            <= 1'b0;
         cols_set       <= 1'b0;
         num_cols       <= '0;
         err            <= 1'b0;
         row_addr_in    <= '0;
         col_addr_in    <= '0;
         partial_vec_in <= '0;
      end else begin
         if (bad || drop) err <= 1'b1;
         if (state == FILL) begin
            acc      <= acc_nxt;
            cell_cnt <= cnt_nxt;
            col      <= col_nxt;
         end
         if (issue_go) begin
            row_addr_in    <= row;
            col_addr_in    <= col_base;
            partial_vec_in <= acc_nxt;
            acc            <= '0;
            cell_cnt       <= '0;
            eol            <= vec_full ? end_req : 1'b1;
            fin            <= end_req;
         end
         if (complete) begin
            if (!cols_set) begin
               num_cols <= col_nxt[COL_W-1:0];
               cols_set <= 1'b1;
            end else if (col_nxt != {1'b0, num_cols}) begin
               err <= 1'b1;
            end
            if (row_max) err <= 1'b1;
            else         row <= row + 1'b1;
            col <= '0;
            eol <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_grid_loader.sv
// Directed bench for grid_loader with DATA_W=ROW_W=COL_W=4; writes are captured into a queue
// and compared against hand-computed row/col/vector triples.
module tb_grid_loader;

   localparam int DW  = 4;
   localparam int RW  = 4;
   localparam int CLW = 4;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           char_valid = 1'b0;
   logic [7:0]     char_in = 8'h00;
   logic           char_ready;
   logic           end_in = 1'b0;
   logic           write_en;
   logic [RW-1:0]  row_addr_in;
   logic [CLW-1:0] col_addr_in;
   logic [DW-1:0]  partial_vec_in;
   logic           busy = 1'b0;
   logic           done;
   logic [RW-1:0]  num_rows;
   logic [CLW-1:0] num_cols;
   logic           err;

   int checks = 0;
   int errors = 0;
   logic [11:0] wq[$];

   always #5 clock = ~clock;

   grid_loader #(.DATA_W(DW), .ROW_W(RW), .COL_W(CLW)) dut (
      .clock(clock), .reset(reset), .char_valid(char_valid), .char_in(char_in),
      .char_ready(char_ready), .end_in(end_in), .write_en(write_en),
      .row_addr_in(row_addr_in), .col_addr_in(col_addr_in), .partial_vec_in(partial_vec_in),
      .busy(busy), .done(done), .num_rows(num_rows), .num_cols(num_cols), .err(err)
   );

   always @(negedge clock) begin
      #1;
      if (write_en) wq.push_back({row_addr_in, col_addr_in, partial_vec_in});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input int r, input int c, input logic [3:0] v);
      logic [11:0] e;
      e = {r[3:0], c[3:0], v};
      chk(tag, (wq.size() == 0) ? 32'hdeadbeef : {20'h0, wq.pop_front()}, {20'h0, e});
   endtask

   task automatic drive(input logic v, input logic [7:0] b, input logic e);
      int n;
      n = 0;
      while (!char_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!char_ready) begin
         chk("ready_timeout", 32'(char_ready), 1);
      end else begin
         char_valid = v;
         char_in    = b;
         end_in     = e;
         @(negedge clock);
         char_valid = 1'b0;
         end_in     = 1'b0;
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) drive(1'b1, s[i], 1'b0);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0; char_valid = 1'b0; end_in = 1'b0; busy = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      wq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic held_we, held_rdy;

      #1;
      chk("rst_char_ready", 32'(char_ready), 0);
      chk("rst_write_en", 32'(write_en), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_num_rows", 32'(num_rows), 0);
      chk("rst_num_cols", 32'(num_cols), 0);
      chk("rst_addr", 32'({row_addr_in, col_addr_in, partial_vec_in}), 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("ready_after_rst", 32'(char_ready), 1);

      // single row exactly one vector wide, then end strobe
      send_str("@.@@\n");
      drive(1'b0, 8'h00, 1'b1);
      settle(4);
      pop_chk("t1_w0", 0, 0, 4'b1101);
      chk("t1_nwr", wq.size(), 0);
      chk("t1_num_rows", 32'(num_rows), 1);
      chk("t1_num_cols", 32'(num_cols), 4);
      chk("t1_done", 32'(done), 1);
      chk("t1_err", 32'(err), 0);

      // two rows of six cells, each split into two vectors
      do_reset();
      send_str("@@.@@.\n..@...\n");
      settle(4);
      pop_chk("t2_w0", 0, 0, 4'b1011);
      pop_chk("t2_w1", 0, 4, 4'b0001);
      pop_chk("t2_w2", 1, 0, 4'b0100);
      pop_chk("t2_w3", 1, 4, 4'b0000);
      chk("t2_num_rows", 32'(num_rows), 2);
      chk("t2_num_cols", 32'(num_cols), 6);
      chk("t2_err", 32'(err), 0);
      chk("t2_done", 32'(done), 0);

      // busy held while a full vector waits
      do_reset();
      busy = 1'b1;
      send_str("@@@@");
      held_we = 1'b0; held_rdy = 1'b0;
      repeat (10) begin
         held_we  |= write_en;
         held_rdy |= char_ready;
         @(negedge clock);
      end
      chk("t3_we_held", 32'(held_we), 0);
      chk("t3_rdy_held", 32'(held_rdy), 0);
      chk("t3_nwr_held", wq.size(), 0);
      busy = 1'b0;
      settle(4);
      chk("t3_nwr", wq.size(), 1);
      pop_chk("t3_w0", 0, 0, 4'b1111);
      chk("t3_ready_again", 32'(char_ready), 1);

      // width mismatch, with a carriage return that must be ignored
      do_reset();
      send_str("@.\r\n@.@\n");
      settle(4);
      pop_chk("t4_w0", 0, 0, 4'b0001);
      pop_chk("t4_w1", 1, 0, 4'b0101);
      chk("t4_err", 32'(err), 1);
      chk("t4_num_cols", 32'(num_cols), 2);
      chk("t4_num_rows", 32'(num_rows), 2);

      // illegal char then blank line terminates
      do_reset();
      send_str("@x\n\n");
      settle(4);
      pop_chk("t5_w0", 0, 0, 4'b0001);
      chk("t5_err", 32'(err), 1);
      chk("t5_done", 32'(done), 1);
      char_valid = 1'b1; char_in = 8'h40;
      held_rdy = 1'b0;
      repeat (5) begin
         held_rdy |= char_ready;
         @(negedge clock);
      end
      char_valid = 1'b0;
      chk("t5_rdy_after_done", 32'(held_rdy), 0);
      chk("t5_nwr_after_done", wq.size(), 0);
      chk("t5_num_rows", 32'(num_rows), 1);

      // newline and end strobe in the same cycle
      do_reset();
      send_str("@@");
      drive(1'b1, 8'h0A, 1'b1);
      settle(4);
      pop_chk("t6_w0", 0, 0, 4'b0011);
      chk("t6_nwr", wq.size(), 0);
      chk("t6_done", 32'(done), 1);
      chk("t6_num_rows", 32'(num_rows), 1);
      chk("t6_num_cols", 32'(num_cols), 2);

      // 17 cells on a 16-column grid: last cell dropped
      do_reset();
      for (int k = 0; k < 17; k++) drive(1'b1, 8'h40, 1'b0);
      drive(1'b1, 8'h0A, 1'b0);
      settle(4);
      pop_chk("t7_w0", 0, 0, 4'b1111);
      pop_chk("t7_w1", 0, 4, 4'b1111);
      pop_chk("t7_w2", 0, 8, 4'b1111);
      pop_chk("t7_w3", 0, 12, 4'b1111);
      chk("t7_nwr", wq.size(), 0);
      chk("t7_err", 32'(err), 1);
      chk("t7_num_rows", 32'(num_rows), 1);

      // reset asserted while waiting on mem
      do_reset();
      send_str("@.\n@@@@");
      chk("t8_we_latency", 32'(write_en), 1);
      @(negedge clock);
      busy = 1'b1;
      chk("t8_wait_rdy", 32'(char_ready), 0);
      #3;
      reset = 1'b0;
      #1;
      chk("t8_rst_we", 32'(write_en), 0);
      chk("t8_rst_rdy", 32'(char_ready), 0);
      chk("t8_rst_addr", 32'({row_addr_in, col_addr_in}), 0);
      chk("t8_rst_vec", 32'(partial_vec_in), 0);
      chk("t8_rst_num_rows", 32'(num_rows), 0);
      chk("t8_rst_num_cols", 32'(num_cols), 0);
      pop_chk("t8_w0", 0, 0, 4'b0001);
      pop_chk("t8_w1", 1, 0, 4'b1111);
      @(negedge clock);
      reset = 1'b1; busy = 1'b0;
      @(negedge clock);
      send_str("@\n");
      drive(1'b0, 8'h00, 1'b1);
      settle(4);
      pop_chk("t8_restart_w0", 0, 0, 4'b0001);
      chk("t8_restart_rows", 32'(num_rows), 1);
      chk("t8_restart_done", 32'(done), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/grid_loader.md
# grid_loader

Upstream stage for `mem`. Consumes the puzzle input as a byte stream of grid characters ('@' occupied, '.' empty, '\n' end of row). It packs each row into `TX_DATA_WIDTH`-bit partial vectors and issues one `mem` write per vector, using `mem`'s write_en/busy handshake. It also reports grid dimensions and sticky error status to the controller.

## Interface
- `DATA_W`, default `` `TX_DATA_WIDTH ``: cells per partial vector.
- `ROW_W`, default `` `BANK_ADDR_WIDTH ``: row address width.
- `COL_W`, default `` `COL_ADDR_WIDTH ``: column address width. This is the cell index of bit 0 of the vector.
- `clock` in, 1 bit: single clock; all state on posedge.
- `reset` in, 1 bit: asynchronous, active-low. Low clears all state immediately.
- `char_valid` in, 1 bit: `char_in` holds a byte.
- `char_in` in, 8 bits: input character.
- `char_ready` out, 1 bit: loader accepts a byte this cycle.
- `end_in` in, 1 bit: one-cycle strobe marking end of input. Sampled only when `char_ready`=1.
- `write_en` out, 1 bit: one-cycle write request to `mem`.
- `row_addr_in` out, `ROW_W` bits: write row, to `mem`.
- `col_addr_in` out, `COL_W` bits: write column (first cell of vector), to `mem`.
- `partial_vec_in` out, `DATA_W` bits: packed cells. Bit i is cell `col_addr_in`+i; 1 means '@'.
- `busy` in, 1 bit: from `mem`. While high, `mem` cannot take a write.
- `done` out, 1 bit: grid fully written. Sticky until reset.
- `num_rows` out, `ROW_W` bits: rows written.
- `num_cols` out, `COL_W` bits: width of the first row.
- `err` out, 1 bit: sticky error flag.

## Operation
- States:
  - FILL: `char_ready`=1; accumulate cells.
  - ISSUE: drive the write.
  - WAIT: wait for `mem` to finish.
  - DONE: terminal.
- FILL, per accepted byte:
  - '@' shifts in 1, '.' shifts in 0, at bit position `cell_cnt`.
  - `col` increments per cell.
  - When `cell_cnt` reaches `DATA_W`, go to ISSUE.
- '\n' in FILL:
  - If the row has ≥1 cell, pad the remaining vector bits with 0 and go to ISSUE with `eol`=1.
  - If the row has 0 cells (blank line), go to DONE.
- '\r' is ignored. Any other byte is treated as '.' and sets `err`.
- `end_in` in FILL:
  - With a partial row pending, flush it as if '\n' had been received, then go to DONE after WAIT.
  - With nothing pending, go straight to DONE.
- ISSUE:
  - When `busy`=0, assert `write_en` for exactly one cycle with stable addr/data, then go to WAIT.
  - While `busy`=1, hold without asserting.
- WAIT:
  - Stay for at least one cycle, then until `busy`=0. Then return to FILL (or DONE if a flush was pending).
  - If `eol`, increment `row` and clear `col` and `cell_cnt`.
- Row width rules:
  - The first completed row latches `num_cols`.
  - Any later row whose length ≠ `num_cols` sets `err`; the row is still written.
- Row overflow: if a '\n' would advance `row` past `2^ROW_W`-1, set `err` and go to DONE.
- `num_rows` equals the number of completed rows.
- Column overflow: a cell beyond `2^COL_W`-1 sets `err` and is dropped.
- DONE: `done`=1, `char_ready`=0, no further writes.

## Timing
- Reset values:
  - `write_en`=0, `char_ready`=0 during reset and 1 in the first cycle after deassertion.
  - `done`=0, `err`=0, `num_rows`=0, `num_cols`=0.
  - `row_addr_in`, `col_addr_in` and `partial_vec_in` are 0.
- A byte is consumed on the posedge where `char_valid` && `char_ready`.
- `char_ready` is 0 throughout ISSUE and WAIT.
- Latency: when a byte completes a vector, `write_en` rises on the following cycle if `busy`=0.
- Minimum turnaround is 3 cycles from the completing byte back to FILL (ISSUE, one WAIT cycle, resume).
- `row_addr_in`, `col_addr_in` and `partial_vec_in` are registered. They stay stable from the ISSUE entry until WAIT exits.
- `end_in` and '\n' in the same cycle are treated as '\n' followed by `end_in`: one flush, then DONE.
- Asserting `reset` mid-write drops the transaction. `write_en` falls immediately (asynchronously).

## Test plan
Vector widths below assume `DATA_W`=4.
- Stream "@.@@\n" then end_in -> one write: row 0, col 0, vec 4'b1101. Then `num_rows`=1, `num_cols`=4, `done`=1, `err`=0.
- Stream "@@.@@.\n..@...\n" -> writes, in order:
  - row 0 col 0 vec 4'b1011
  - row 0 col 4 vec 4'b0001
  - row 1 col 0 vec 4'b0100
  - row 1 col 4 vec 4'b0000

  Then `num_rows`=2.
- Hold `busy`=1 for 10 cycles while a vector is ready -> `write_en` stays 0 and `char_ready`=0. A single `write_en` pulse follows the cycle after `busy` drops.
- Send "@.\n@.@\n" -> both rows are written and `err`=1 (row width mismatch). `num_cols`=2.
- Send "@x\n\n" -> row 0 vec 4'b0001, `err`=1, `done`=1 after the blank line. Further `char_valid` is not accepted.
- Assert `reset` low during WAIT -> all outputs return to their reset values within the same cycle. The next stream starts again at row 0.
